// File: rtl/narnet_pkg.sv
// Shared types and defaults for the NAR-Net driver.
// State encoding, default word widths and step counter width.
package narnet_pkg;

    localparam int NARNET_N = 8;
    localparam int NARNET_Q = 7;
    localparam int STEP_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/narnet_driver_if.sv
// Bundle of upstream, network and downstream signals of the driver.
// master = driver side, slave = environment side.
interface narnet_driver_if
    import narnet_pkg::*;
#(
    parameter int N = NARNET_N
);

    logic [N-1:0]      s_data;
    logic              s_valid;
    logic              s_ready;
    logic              closed_loop;
    logic [STEP_W-1:0] horizon;

    logic [N-1:0]      net_x;
    logic              net_x_ready;
    logic              net_enable;
    logic              net_rst;
    logic [N-1:0]      net_y;
    logic              net_out_ready;

    logic [N-1:0]      m_data;
    logic [STEP_W-1:0] m_step;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    logic              busy;
    logic              timeout_err;

    modport master (
        input  s_data, s_valid, closed_loop, horizon,
        input  net_y, net_out_ready, m_ready,
        output s_ready, net_x, net_x_ready, net_enable, net_rst,
        output m_data, m_step, m_last, m_valid, busy, timeout_err
    );

    modport slave (
        output s_data, s_valid, closed_loop, horizon,
        output net_y, net_out_ready, m_ready,
        input  s_ready, net_x, net_x_ready, net_enable, net_rst,
        input  m_data, m_step, m_last, m_valid, busy, timeout_err
    );

endinterface

// File: rtl/narnet_drv_watchdog.sv
// Result watchdog: counts cycles spent waiting for the network
// and raises a one-cycle expire plus a sticky error flag.
module narnet_drv_watchdog #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wait,
    input  logic i_done,
    output logic o_expire,
    output logic o_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_hit;

    assign w_hit    = i_wait && !i_done &&
                      (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign o_expire = w_hit;
    assign o_err    = r_err;

    // Wait-cycle counter, cleared whenever the wait ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_wait || i_done || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky error, only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_hit) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/narnet_driver.sv
// NAR-Net initiator sequencer: issue sample, wait result, emit,
// optionally feed back. Watchdog under NARNET_DRV_WATCHDOG_EN.
module narnet_driver
    import narnet_pkg::*;
#(
    parameter int N           = NARNET_N,
    parameter int Q           = NARNET_Q,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic            clk,
    input  logic            rst,
    narnet_driver_if.master bus
);

    if (Q >= N) begin : g_bad_q
        $error("Q must be smaller than N");
    end

    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("TIMEOUT_CYC must be at least 1");
    end

    drv_state_t        r_state;
    drv_state_t        w_next;

    logic [N-1:0]      r_x;
    logic [N-1:0]      r_y;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] r_hz;
    logic              r_cl;
    logic              r_net_rst;
    logic              r_net_en;

    logic              w_idle;
    logic              w_accept;
    logic              w_result;
    logic              w_emit_hs;
    logic              w_last;
    logic              w_expire;
    logic              w_err;

`ifdef NARNET_DRV_WATCHDOG_EN
    narnet_drv_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_wait   (r_state == WAIT),
        .i_done   (bus.net_out_ready),
        .o_expire (w_expire),
        .o_err    (w_err)
    );
`else
    assign w_expire = 1'b0;
    assign w_err    = 1'b0;
`endif

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = w_idle && !rst && bus.s_valid;
    assign w_result  = (r_state == WAIT) && bus.net_out_ready;
    assign w_emit_hs = (r_state == EMIT) && bus.m_ready;
    assign w_last    = !(r_cl && (r_step < r_hz));

    assign bus.s_ready     = w_idle && !rst;
    assign bus.net_x       = r_x;
    assign bus.net_x_ready = (r_state == ISSUE);
    assign bus.net_enable  = r_net_en;
    assign bus.net_rst     = r_net_rst;
    assign bus.m_valid     = (r_state == EMIT);
    assign bus.m_data      = r_y;
    assign bus.m_step      = r_step;
    assign bus.m_last      = (r_state == EMIT) && w_last;
    assign bus.busy        = !w_idle;
    assign bus.timeout_err = w_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.s_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (w_expire) begin
                    w_next = IDLE;
                end else if (bus.net_out_ready) begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                if (bus.m_ready) begin
                    w_next = w_last ? IDLE : ISSUE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Sample, result and step registers; x also drives net_x.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_step <= '0;
            r_hz   <= '0;
            r_cl   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x    <= bus.s_data;
                r_cl   <= bus.closed_loop;
                r_hz   <= bus.horizon;
                r_step <= '0;
            end
            if (w_result) begin
                r_y <= bus.net_y;
            end
            if (w_emit_hs && !w_last) begin
                r_x    <= r_y;
                r_step <= r_step + 1'b1;
            end
        end
    end

    // Network reset follows rst by one cycle, plus watchdog pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_net_rst <= 1'b1;
        end else begin
            r_net_rst <= w_expire;
        end
    end

    // Network enable: low in reset, high forever after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_net_en <= 1'b0;
        end else begin
            r_net_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_narnet_driver.sv
// Bench for narnet_driver with a behavioural network model
// (y = x + 0x10, result 40 cycles after the strobe).
module tb_narnet_driver;

    typedef struct {
        logic [7:0] d;
        logic [7:0] st;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] x;
        logic       cl;
        logic [7:0] hz;
        int         strobes;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    narnet_driver_if #(.N(8)) bus ();

    narnet_driver #(
        .N           (8),
        .Q           (7),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    int   have_strobe = 0;
    int   strobe_cnt = 0;
    int   last_hs_cyc = 0;
    int   m_cnt = 0;
    logic [7:0] m_y = 8'h00;
    logic model_en = 1'b1;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_expect(input logic [7:0] x, input logic cl,
                               input logic [7:0] hz);
        int   n;
        exp_t e;
        logic [7:0] y;
        n = cl ? int'(hz) : 0;
        y = x;
        for (int k = 0; k <= n; k++) begin
            y = y + 8'h10;
            e.d = y;
            e.st = 8'(k);
            e.last = (k == n);
            sbq.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] x, input logic cl,
                        input logic [7:0] hz, input logic do_push);
        logic ok;
        @(posedge clk); #1;
        bus.s_data = x;
        bus.closed_loop = cl;
        bus.horizon = hz;
        bus.s_valid = 1'b1;
        if (do_push) push_expect(x, cl, hz);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("issue_strobe", 32'(bus.net_x_ready), 32'd1);
        chk("issue_net_x", 32'(bus.net_x), 32'(x));
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    // Cycle counter.
    always @(posedge clk) cyc++;

    // Network model.
    always @(negedge clk) begin
        bus.net_out_ready = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && model_en) begin
                bus.net_out_ready = 1'b1;
                bus.net_y = m_y;
            end
        end
        if (bus.net_x_ready) begin
            m_cnt = 40;
            m_y = bus.net_x + 8'h10;
        end
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.net_x_ready) begin
                if (have_strobe != 0)
                    chk("strobe_gap", 32'(cyc - last_strobe >= 3), 32'd1);
                have_strobe = 1;
                last_strobe = cyc;
                strobe_cnt++;
            end
            if (bus.m_valid && sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_m_valid: got %0h expected none",
                         bus.m_data);
            end else if (bus.m_valid && bus.m_ready) begin
                e = sbq.pop_front();
                chk("m_data", 32'(bus.m_data), 32'(e.d));
                chk("m_step", 32'(bus.m_step), 32'(e.st));
                chk("m_last", 32'(bus.m_last), 32'(e.last));
                last_hs_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[5];
        int   s0;
        logic ok;
        logic [7:0] held;

        vt[0] = '{x: 8'h30, cl: 1'b0, hz: 8'd0, strobes: 1};
        vt[1] = '{x: 8'h30, cl: 1'b1, hz: 8'd3, strobes: 4};
        vt[2] = '{x: 8'h00, cl: 1'b1, hz: 8'd0, strobes: 1};
        vt[3] = '{x: 8'hc0, cl: 1'b0, hz: 8'd5, strobes: 1};
        vt[4] = '{x: 8'he0, cl: 1'b1, hz: 8'd2, strobes: 3};

        bus.s_data = 8'h00;
        bus.s_valid = 1'b0;
        bus.closed_loop = 1'b0;
        bus.horizon = 8'd0;
        bus.m_ready = 1'b1;

        @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_net_rst", 32'(bus.net_rst), 32'd1);
        chk("rst_net_en", 32'(bus.net_enable), 32'd0);
        chk("rst_x_ready", 32'(bus.net_x_ready), 32'd0);
        chk("rst_net_x", 32'(bus.net_x), 32'd0);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_m_step", 32'(bus.m_step), 32'd0);
        chk("rst_m_last", 32'(bus.m_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tmo", 32'(bus.timeout_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("post_rst_net_rst", 32'(bus.net_rst), 32'd1);
        @(negedge clk);
        chk("net_rst_low", 32'(bus.net_rst), 32'd0);
        chk("net_en_high", 32'(bus.net_enable), 32'd1);

        for (int v = 0; v < 5; v++) begin
            s0 = strobe_cnt;
            send(vt[v].x, vt[v].cl, vt[v].hz, 1'b1);
            wait_done();
            chk("strobe_count", 32'(strobe_cnt - s0), 32'(vt[v].strobes));
            chk("idle_s_ready", 32'(bus.s_ready), 32'd1);
        end

        // Back-pressure in EMIT with a pending upstream sample.
        bus.m_ready = 1'b0;
        s0 = strobe_cnt;
        send(8'h30, 1'b0, 8'd0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_m_valid_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.s_data = 8'h55;
        bus.closed_loop = 1'b0;
        bus.s_valid = 1'b1;
        push_expect(8'h55, 1'b0, 8'd0);
        held = bus.m_data;
        chk("bp_m_data", 32'(held), 32'h40);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(bus.m_data), 32'(held));
            chk("bp_hold_valid", 32'(bus.m_valid), 32'd1);
            chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
            chk("bp_no_strobe", 32'(bus.net_x_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_second_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        wait_done();
        chk("bp_strobes", 32'(strobe_cnt - s0), 32'd2);

        // Back-to-back samples with s_valid held.
        @(posedge clk); #1;
        bus.s_data = 8'h00;
        bus.closed_loop = 1'b0;
        bus.s_valid = 1'b1;
        push_expect(8'h00, 1'b0, 8'd0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b_first_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.s_data = 8'h20;
        push_expect(8'h20, 1'b0, 8'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b_second_accept", 32'(ok), 32'd1);
        chk("b2b_accept_gap", 32'(cyc - last_hs_cyc), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        wait_done();

        // Reset in the middle of WAIT.
        send(8'h30, 1'b0, 8'd0, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_net_rst", 32'(bus.net_rst), 32'd1);
        chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_extra", 32'(bus.net_rst), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("mid_rst_no_valid", 32'(bus.m_valid), 32'd0);
            chk("mid_rst_no_strobe", 32'(bus.net_x_ready), 32'd0);
        end
        chk("mid_rst_net_rst_low", 32'(bus.net_rst), 32'd0);
        chk("mid_rst_idle", 32'(bus.s_ready), 32'd1);
        send(8'h10, 1'b1, 8'd1, 1'b1);
        wait_done();

`ifdef NARNET_DRV_WATCHDOG_EN
        model_en = 1'b0;
        send(8'h30, 1'b0, 8'd0, 1'b0);
        s0 = last_strobe;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.net_rst) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wd_fired", 32'(ok), 32'd1);
        chk("wd_delay", 32'(cyc - (s0 + 1)), 32'd50);
        chk("wd_err", 32'(bus.timeout_err), 32'd1);
        chk("wd_no_valid", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        chk("wd_pulse_len", 32'(bus.net_rst), 32'd0);
        chk("wd_idle", 32'(bus.busy), 32'd0);
        model_en = 1'b1;
        send(8'h10, 1'b0, 8'd0, 1'b1);
        wait_done();
        chk("wd_sticky", 32'(bus.timeout_err), 32'd1);
`else
        chk("tmo_tied_low", 32'(bus.timeout_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
